// File: rtl/add_byteserial_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract controller.
package add_byteserial_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_BAD  = 2'd3
   } state_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/add_byteserial_ctrl_add8.sv
// 8-bit ripple-carry adder slice, shared across all bytes of a wide operation.
module add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);

   logic [8:0] c;

   assign c[0] = ci;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_fa
         assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign co = c[8];

endmodule

// File: rtl/add_byteserial_ctrl.sv
// Wide add/subtract done one byte per clock through a single add8 slice,
// least significant byte first, with a start/busy/done handshake.
module add_byteserial_ctrl
   import add_byteserial_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sub,
   input  logic [BYTE_W*NBYTES-1:0]   a,
   input  logic [BYTE_W*NBYTES-1:0]   b,
   input  logic                       cin,
   output logic                       busy,
   output logic                       done,
   output logic [BYTE_W*NBYTES-1:0]   z,
   output logic                       cout,
   output logic                       ovf
);

   localparam int W    = BYTE_W * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t            state_reg, state_next;
   logic [IDXW-1:0]   idx_reg;
   logic [W-1:0]      a_reg, b_reg, z_reg;
   logic              carry_reg, cout_reg, ovf_reg;

   logic [7:0]        slice_a, slice_b, slice_s;
   logic              slice_co;
   logic              last_byte;

   assign slice_a   = a_reg[BYTE_W*idx_reg +: BYTE_W];
   assign slice_b   = b_reg[BYTE_W*idx_reg +: BYTE_W];
   assign last_byte = (idx_reg == IDXW'(NBYTES - 1));

   add8 u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_reg),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_byte) state_next = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Subtraction is A + ~B + ~borrow, so B is inverted once at capture time.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         z_reg     <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= sub ? ~b : b;
                  carry_reg <= cin ^ sub;
                  idx_reg   <= '0;
                  z_reg     <= '0;
               end
            end
            ST_RUN: begin
               z_reg[BYTE_W*idx_reg +: BYTE_W] <= slice_s;
               carry_reg <= slice_co;
               idx_reg   <= idx_reg + 1'b1;
               if (last_byte) begin
                  cout_reg <= slice_co;
                  // a7^b7^s7 recovers the carry into bit 7 of the top slice.
                  ovf_reg  <= slice_a[7] ^ slice_b[7] ^ slice_s[7] ^ slice_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign z    = z_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_add_byteserial_ctrl.sv
// Self-checking bench: NBYTES=4 directed scenarios plus NBYTES=2/8 random sweeps.
module tb_add_byteserial_ctrl;

   typedef struct {
      logic [63:0] z;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a_in, b_in;
   logic        sub_in, cin_in;
   logic        start2, start4, start8;

   logic        busy2, done2, cout2, ovf2;
   logic        busy4, done4, cout4, ovf4;
   logic        busy8, done8, cout8, ovf8;
   logic [15:0] z2;
   logic [31:0] z4;
   logic [63:0] z8;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   add_byteserial_ctrl #(.NBYTES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub_in),
      .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in),
      .busy(busy2), .done(done2), .z(z2), .cout(cout2), .ovf(ovf2));

   add_byteserial_ctrl #(.NBYTES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub_in),
      .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in),
      .busy(busy4), .done(done4), .z(z4), .cout(cout4), .ovf(ovf4));

   add_byteserial_ctrl #(.NBYTES(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub_in),
      .a(a_in), .b(b_in), .cin(cin_in),
      .busy(busy8), .done(done8), .z(z8), .cout(cout8), .ovf(ovf8));

   // Behavioural W-bit reference: plain wide arithmetic, signed overflow from sign rules.
   function automatic exp_t model(int nb, logic [63:0] a, logic [63:0] b,
                                  logic sub, logic cin);
      exp_t        e;
      int          w;
      logic [64:0] mask, am, bm, full;
      w    = 8 * nb;
      mask = (65'd1 << w) - 65'd1;
      am   = {1'b0, a} & mask;
      bm   = {1'b0, b} & mask;
      if (!sub) begin
         full   = am + bm + {64'd0, cin};
         e.cout = full[w];
      end else begin
         full   = am - bm - {64'd0, cin};
         e.cout = (am >= bm + {64'd0, cin});
      end
      full = full & mask;
      e.z  = full[63:0];
      if (!sub) e.ovf = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
      else      e.ovf = (am[w-1] != bm[w-1]) && (full[w-1] != am[w-1]);
      return e;
   endfunction

   function automatic logic get_busy(int nb);
      case (nb)
         2:       return busy2;
         4:       return busy4;
         default: return busy8;
      endcase
   endfunction

   function automatic logic get_done(int nb);
      case (nb)
         2:       return done2;
         4:       return done4;
         default: return done8;
      endcase
   endfunction

   function automatic logic get_cout(int nb);
      case (nb)
         2:       return cout2;
         4:       return cout4;
         default: return cout8;
      endcase
   endfunction

   function automatic logic get_ovf(int nb);
      case (nb)
         2:       return ovf2;
         4:       return ovf4;
         default: return ovf8;
      endcase
   endfunction

   function automatic logic [63:0] get_z(int nb);
      case (nb)
         2:       return {48'd0, z2};
         4:       return {32'd0, z4};
         default: return z8;
      endcase
   endfunction

   task automatic set_start(int nb, logic v);
      start2 = (nb == 2) ? v : 1'b0;
      start4 = (nb == 4) ? v : 1'b0;
      start8 = (nb == 8) ? v : 1'b0;
   endtask

   // One full transaction on the selected instance, scrambling inputs after acceptance.
   task automatic do_op(int nb, logic [63:0] a, logic [63:0] b, logic sub, logic cin);
      exp_t        e;
      int          lat, busy_cnt;
      bit          got;
      logic [63:0] z_done;
      exp_q.push_back(model(nb, a, b, sub, cin));
      @(negedge clk);
      a_in = a; b_in = b; sub_in = sub; cin_in = cin;
      set_start(nb, 1'b1);
      @(posedge clk);
      lat = 0; busy_cnt = 0; got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         set_start(nb, 1'b0);
         a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
         sub_in = 1'($urandom); cin_in = 1'($urandom);
         lat++;
         if (get_busy(nb)) busy_cnt++;
         if (get_done(nb)) got = 1;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (!got || lat != nb + 1) begin
         n_errors++;
         $display("FAIL latency nb=%0d: got done=%0b after %0d cycles, required %0d", nb, got, lat, nb + 1);
      end
      n_checks++;
      if (busy_cnt != nb + 1) begin
         n_errors++;
         $display("FAIL busy_len nb=%0d: got %0d, required %0d", nb, busy_cnt, nb + 1);
      end
      z_done = get_z(nb);
      n_checks++;
      if (z_done !== e.z) begin
         n_errors++;
         $display("FAIL z nb=%0d a=%h b=%h sub=%0b cin=%0b: got %h, required %h", nb, a, b, sub, cin, z_done, e.z);
      end
      n_checks++;
      if (get_cout(nb) !== e.cout) begin
         n_errors++;
         $display("FAIL cout nb=%0d a=%h b=%h sub=%0b cin=%0b: got %0b, required %0b", nb, a, b, sub, cin, get_cout(nb), e.cout);
      end
      n_checks++;
      if (get_ovf(nb) !== e.ovf) begin
         n_errors++;
         $display("FAIL ovf nb=%0d a=%h b=%h sub=%0b cin=%0b: got %0b, required %0b", nb, a, b, sub, cin, get_ovf(nb), e.ovf);
      end
      @(negedge clk);
      n_checks++;
      if (get_done(nb) !== 1'b0 || get_busy(nb) !== 1'b0) begin
         n_errors++;
         $display("FAIL after_done nb=%0d: got done=%0b busy=%0b, required 0 0", nb, get_done(nb), get_busy(nb));
      end
      n_checks++;
      if (get_z(nb) !== e.z) begin
         n_errors++;
         $display("FAIL z_hold nb=%0d: got %h, required %h", nb, get_z(nb), e.z);
      end
      $display("op nb=%0d a=%h b=%h sub=%0b cin=%0b z=%h cout=%0b ovf=%0b lat=%0d",
               nb, a, b, sub, cin, z_done, get_cout(nb), get_ovf(nb), lat);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      foreach (exp_q[i]) exp_q.delete(i);
      for (int nb = 2; nb <= 8; nb *= 2) begin
         n_checks++;
         if (get_busy(nb) !== 1'b0 || get_done(nb) !== 1'b0 || get_z(nb) !== 64'd0 ||
             get_cout(nb) !== 1'b0 || get_ovf(nb) !== 1'b0) begin
            n_errors++;
            $display("FAIL reset nb=%0d: got busy=%0b done=%0b z=%h cout=%0b ovf=%0b, required all 0",
                     nb, get_busy(nb), get_done(nb), get_z(nb), get_cout(nb), get_ovf(nb));
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      do_op(4, 64'h0000_00FF, 64'h0000_0001, 1'b0, 1'b0);
      do_op(4, 64'hFFFF_FFFF, 64'h0,         1'b0, 1'b1);
      do_op(4, 64'h7FFF_FFFF, 64'h1,         1'b0, 1'b0);
   endtask

   task automatic test_sub();
      do_op(4, 64'd10,        64'd3, 1'b1, 1'b0);
      do_op(4, 64'd3,         64'd10, 1'b1, 1'b0);
      do_op(4, 64'h8000_0000, 64'd1, 1'b1, 1'b0);
      do_op(4, 64'd5,         64'd5, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t last;
      last.z = get_z(4); last.cout = 1'b0; last.ovf = 1'b0;
      for (int k = 0; k <= 24; k++) begin
         @(negedge clk);
         if (k % 6 == 5) begin
            n_checks++;
            if (done4 !== 1'b1) begin
               n_errors++;
               $display("FAIL b2b_done k=%0d: got %0b, required 1", k, done4);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_checks++;
               if (z4 !== e.z[31:0] || cout4 !== e.cout || ovf4 !== e.ovf) begin
                  n_errors++;
                  $display("FAIL b2b_result k=%0d: got z=%h cout=%0b ovf=%0b, required z=%h cout=%0b ovf=%0b",
                           k, z4, cout4, ovf4, e.z[31:0], e.cout, e.ovf);
               end
               last = e;
               $display("b2b op k=%0d z=%h cout=%0b ovf=%0b", k, z4, cout4, ovf4);
            end
         end else begin
            n_checks++;
            if (done4 !== 1'b0) begin
               n_errors++;
               $display("FAIL b2b_nodone k=%0d: got %0b, required 0", k, done4);
            end
         end
         if (k % 6 == 0 && k > 0) begin
            n_checks++;
            if (z4 !== last.z[31:0]) begin
               n_errors++;
               $display("FAIL b2b_hold k=%0d: got %h, required %h", k, z4, last.z[31:0]);
            end
         end
         a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
         sub_in = 1'($urandom); cin_in = 1'($urandom);
         if (k % 6 == 0 && k < 24) begin
            start4 = 1'b1;
            exp_q.push_back(model(4, a_in, b_in, sub_in, cin_in));
         end else if (k == 24) begin
            start4 = 1'b0;
         end
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      a_in = 64'd5; b_in = 64'd7; sub_in = 1'b0; cin_in = 1'b0;
      start4 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (k == 3) rst = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || z4 !== 32'd0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
         n_errors++;
         $display("FAIL midop_reset: got busy=%0b done=%0b z=%h cout=%0b ovf=%0b, required all 0",
                  busy4, done4, z4, cout4, ovf4);
      end
      rst = 1'b0;
      do_op(4, 64'd5, 64'd5, 1'b0, 1'b0);
   endtask

   task automatic test_random(int nb);
      for (int i = 0; i < 1000; i++)
         do_op(nb, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_in = '0; b_in = '0; sub_in = 1'b0; cin_in = 1'b0;
      start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_midop();
      test_random(2);
      test_random(8);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/add_byteserial_ctrl.md
Name: add_byteserial_ctrl

Overview:
Sequencing controller that performs wide (NBYTES x 8-bit) add/subtract by time-multiplexing one instance of the team's 8-bit ripple adder (add8), one byte per clock, least significant byte first. A start/busy/done handshake lets the lab datapath trade area for latency. The block captures the operands, steps a byte index, and keeps the inter-byte carry in a register. It also assembles the result and reports carry-out and signed overflow.

Parameters:
NBYTES, 4, number of 8-bit slices in each operand (legal range 2..16; total width W = 8*NBYTES)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only when busy=0
sub  input  1  0: Z = A + B + cin; 1: Z = A - B - cin (cin acts as borrow-in)
a  input  W  operand A, captured on the accepted start edge
b  input  W  operand B, captured on the accepted start edge
cin  input  1  carry-in (add) or borrow-in (sub), captured with the operands
busy  output  1  high while an operation is in flight (states RUN and DONE)
done  output  1  one-cycle pulse; result outputs valid from this cycle on
z  output  W  result, held stable until the next accepted start
cout  output  1  add: final carry-out; sub: 1 = no borrow (A >= B + cin, unsigned)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB, top byte

Behaviour:
- Reset: state=IDLE, busy=0, done=0, z=0, cout=0, ovf=0, byte index=0, carry reg=0, captured operands=0. Reset has priority over every other input, including in mid-operation; a partial result is discarded and z returns to 0.
- States:
  - IDLE: busy=0. If start=1, then a_r<=a, b_r<=(sub ? ~b : b), carry<=cin^sub, idx<=0, z cleared to 0, next state RUN. If start=0, stay in IDLE.
  - RUN: busy=1. The add8 slice computes a_r byte[idx] + b_r byte[idx] + carry. On each edge, z byte[idx]<=slice sum, carry<=slice cout, and idx<=idx+1. When idx=NBYTES-1, the edge also loads cout<=slice cout and ovf<=carry-into-bit7 XOR slice cout, and goes to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start is accepted on edge T0.
  - The RUN edges are T1..TNBYTES.
  - done is high during cycle NBYTES+1 after T0.
  - The earliest next start is accepted on the edge that leaves DONE+1, i.e. in IDLE. Throughput is one op per NBYTES+2 cycles.
- start while busy=1 is ignored: no queuing and no error flag. a/b/sub/cin may change freely after the accepting edge.
- z, cout and ovf update only as specified. Between done and the next start they hold their values. During RUN, z shows partial bytes; consumers wait for done.
- Carry-into-bit7 for ovf is taken as a7^b7^s7 of the top slice, so add8 needs no extra port.
- Arithmetic is modulo 2^W. No saturation is applied.

Decomposition:
- Shared package/include (lab_defs): state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the 2'd3 illegal state, which recovers to IDLE.
- Index width localparam IDXW = clog2(NBYTES), computed locally.
- One sub-module: the existing add8, instantiated once as the shared byte slice. Byte select and result write-back use indexed part-selects (a_r[8*idx +: 8]).

Test Plan:
- NBYTES=4, sub=0, a=32'h0000_00FF, b=32'h0000_0001, cin=0, pulse start: carry ripples across bytes; done 5 cycles after the start edge with z=32'h0000_0100, cout=0, ovf=0; busy high for exactly 5 cycles.
- sub=0, a=32'hFFFF_FFFF, b=32'h0, cin=1: z=32'h0, cout=1, ovf=0. Then a=32'h7FFF_FFFF, b=1, cin=0: z=32'h8000_0000, cout=0, ovf=1.
- sub=1, a=32'd10, b=32'd3, cin=0: z=32'd7, cout=1. Then a=3, b=10: z=32'hFFFF_FFF9, cout=0, ovf=0. Then a=32'h8000_0000, b=1: z=32'h7FFF_FFFF, ovf=1.
- Hold start=1 continuously with changing a/b: each op uses the operands present on its accepting edge; done pulses every 6 cycles; z is unchanged between done and the next accept.
- Assert rst for 1 cycle while idx=2 in RUN: the next cycle shows busy=0, done=0, z=0, cout=0, ovf=0. A new start then completes correctly (5+5 → 10).
- Parameter sweep NBYTES=2 and NBYTES=8, each with 1000 random ops plus sub/cin, checked against a behavioural W-bit model for z, cout, ovf, and done timing of NBYTES+1.
